data_memory_banked: RTL
=======================

// Module: data_memory_banked
// PURPOSE
//  Parametrised data memory for the MIPS datapath: byte-addressed, word-organised
//  RAM with per-byte write enables, a registered read port with a valid strobe,
//  and read-during-write forwarding. Sits in the MEM stage; replaces the fixed
//  32x32 data memory and lets the datapath issue a load and a store in one cycle.
// PARAMETERS
//  DATA_WIDTH  32  word width in bits; multiple of 8
//  DEPTH       32  number of words; power of 2, >= 2
//  ADDR_WIDTH  32  width of byte-address inputs
//  INIT_DEMO   1   1: word1=84, word2=11 and all other words 0 at time zero; 0: all words 0
//  Derived: NB = DATA_WIDTH/8; OFS = log2(NB); IDX = log2(DEPTH)
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous active-low reset
//  mem_read    in   1           load request this cycle
//  read_addr   in   ADDR_WIDTH  load byte address
//  mem_write   in   1           store request this cycle
//  write_addr  in   ADDR_WIDTH  store byte address
//  write_data  in   DATA_WIDTH  store data
//  byte_en     in   NB          store byte lanes; bit i enables write_data[8i+7:8i]
//  read_data   out  DATA_WIDTH  load result, registered
//  read_valid  out  1           read_data valid this cycle
//  access_err  out  1           registered error flag (only with DMEM_CHECK_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): read_data=0, read_valid=0, access_err=0. The array is
//    NOT cleared by reset; contents persist across reset. Reset mid-load drops it.
//  - Word index = addr[OFS+IDX-1:OFS]; upper address bits ignored (wrap modulo
//    DEPTH*NB); low OFS bits ignored.
//  - Store: on posedge with mem_write=1, each lane i with byte_en[i]=1 is written;
//    lanes with byte_en[i]=0 keep old value. byte_en=0 is a no-op.
//  - Load: on posedge with mem_read=1, read_data <= word; read_valid <= 1 for
//    exactly one cycle (latency 1). mem_read=0: read_valid <= 0, read_data holds.
//  - Load and store in the same cycle are both performed (no priority, no stall).
//    Same word index: read_data returns merged value (enabled lanes from
//    write_data, other lanes old contents) -- write-first forwarding.
//  - Back-to-back loads: one result per cycle, read_valid stays high.
//  - Store then load of same word next cycle returns the stored value.
//  - No internal state machine beyond the registered read path; no backpressure.
// CONFIGURATION
//  DMEM_CHECK_EN defined:
//   - Access is in error if low OFS address bits != 0 (misaligned) or upper bits
//     above OFS+IDX != 0 (out of range).
//   - Erroneous store: suppressed entirely, array unchanged.
//   - Erroneous load: read_data <= 0, read_valid <= 1.
//   - access_err <= 1 the cycle after any erroneous load or store, else 0.
//   - Same-cycle forwarding applies only when the store is not in error.
//  DMEM_CHECK_EN undefined: no checking; wrap/ignore rules above; access_err tied 0.
// TESTING
//  1 Reset, INIT_DEMO=1: load addr 4 -> read_data=84, read_valid=1 one cycle later;
//    load addr 8 -> 11.
//  2 Store 0xDEADBEEF to addr 12, byte_en=4'b0101, prior word 0 -> load 12 returns
//    0x00AD00EF.
//  3 Same cycle: store 0x12345678 be=4'b1111 and load, both addr 16 -> read_data
//    =0x12345678 next cycle; load 16 again -> 0x12345678.
//  4 Loads to 4,8,12 on consecutive cycles -> read_valid high 3 cycles, data in order;
//    mem_read low -> read_valid low next cycle, read_data holds last value.
//  5 Assert rst_n=0 during a load cycle -> read_valid=0 immediately; after release,
//    load 16 still returns 0x12345678 (array survives reset).
//  6 DMEM_CHECK_EN: store 0xFFFFFFFF to addr 6 -> access_err=1 next cycle, word 1
//    still 84; load addr 128 (DEPTH=32) -> read_data=0, access_err=1. Without macro:
//    load 128 returns word 0, access_err=0.

Source files
------------

// File: rtl/data_memory_banked.sv
// data_memory_banked: byte-addressed word RAM with byte-lane stores, registered read port and write-first forwarding
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset (clears read port only)
//   mem_read, read_addr    load request and byte address
//   mem_write, write_addr  store request and byte address
//   write_data, byte_en    store data and per-byte lane enables
//   read_data, read_valid  registered load result and its one-cycle strobe
//   access_err             registered misaligned/out-of-range flag
// Optional feature: define DMEM_CHECK_EN to enable alignment/range checking;
// without it, low address bits are ignored, addresses wrap and access_err stays 0.
module data_memory_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_DEMO  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    input  logic                      mem_write,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      read_valid,
    output logic                      access_err
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam int IDX = $clog2(DEPTH);

    // Contents are set at configuration time and are never touched by reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
        1: (INIT_DEMO != 0) ? DATA_WIDTH'(84) : '0,
        2: (INIT_DEMO != 0) ? DATA_WIDTH'(11) : '0,
        default: '0
    };

    logic [IDX-1:0]        rdIdx, wrIdx;
    logic                  rdErr, wrErr;
    logic [DATA_WIDTH-1:0] fwdWord;

    assign rdIdx = read_addr[OFS+IDX-1:OFS];
    assign wrIdx = write_addr[OFS+IDX-1:OFS];

`ifdef DMEM_CHECK_EN
    assign rdErr = ((read_addr & ADDR_WIDTH'(NB - 1)) != '0) || ((read_addr >> (OFS + IDX)) != '0);
    assign wrErr = ((write_addr & ADDR_WIDTH'(NB - 1)) != '0) || ((write_addr >> (OFS + IDX)) != '0);
`else
    logic unusedAddr;
    assign unusedAddr = ^{read_addr, write_addr};
    assign rdErr = 1'b0;
    assign wrErr = 1'b0;
`endif

    always_ff @(posedge clk)
        if (mem_write && !wrErr)
            for (int i = 0; i < NB; i++)
                if (byte_en[i]) mem[wrIdx][8*i +: 8] <= write_data[8*i +: 8];

    // A load hitting the word being stored sees the new lanes this cycle.
    always_comb begin
        fwdWord = mem[rdIdx];
        for (int i = 0; i < NB; i++)
            if (mem_write && !wrErr && wrIdx == rdIdx && byte_en[i]) fwdWord[8*i +: 8] = write_data[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            read_valid <= mem_read;
            if (mem_read) read_data <= rdErr ? '0 : fwdWord;
            access_err <= (mem_read && rdErr) || (mem_write && wrErr);
        end
endmodule
